// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX byte FIFO write port
// between NREQ valid/ready byte-stream requesters. A granted requester keeps
// the port until it sends a last byte, reaches MAX_BURST bytes, or drops valid.
// Optional build macro UART_TX_ARB_STATS_EN adds a saturating stall_cnt output
// counting granted cycles where the requester had data but the FIFO was full.
//
// state    | meaning
// ST_IDLE  | no grant; arbitrate among valid requesters starting after rr_last
// ST_GRANT | grant_id owns the FIFO write port
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    fifo_wr,
  output logic [WIDTH-1:0]        fifo_wr_data,
  input  logic                    fifo_full,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
`ifdef UART_TX_ARB_STATS_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [GW-1:0] rr_last_q, rr_last_d;

  logic          g_valid;
  logic          g_last;
  logic [WIDTH-1:0] g_data;
  logic          xfer;
  logic [BW-1:0] burst_inc;
  logic          burst_cap;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] cand_idx;

  // Select the granted requester's valid/last/data.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin search: first valid requester after rr_last, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_idx = GW'((int'(rr_last_q) + i) % NREQ);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Write-port outputs; ready depends only on grant and fifo_full.
  always_comb begin
    busy         = (state_q == ST_GRANT);
    xfer         = busy & g_valid & ~fifo_full;
    fifo_wr      = xfer;
    fifo_wr_data = xfer ? g_data : '0;
    grant_id     = grant_id_q;
    burst_inc    = burst_cnt_q + BW'(1);
    burst_cap    = (burst_inc == BW'(MAX_BURST));
    req_ready    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = busy && (grant_id_q == GW'(i)) && !fifo_full;
    end
  end

  // FSM next state; a full FIFO holds the grant, an idle requester releases it.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    rr_last_d   = rr_last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_GRANT;
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          burst_cnt_d = burst_inc;
        end
        if ((xfer && (g_last || burst_cap)) || !g_valid) begin
          state_d   = ST_IDLE;
          rr_last_d = grant_id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; rr_last resets to NREQ-1 so requester 0 goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      rr_last_q   <= GW'(NREQ - 1);
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      rr_last_q   <= rr_last_d;
    end
  end

`ifdef UART_TX_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of granted cycles blocked by a full FIFO.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (busy && g_valid && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. Messages are loaded into per-requester
// source queues; a transaction-level round-robin model turns them into the
// expected (requester, byte) write stream; a monitor pops and compares it.
module tb_uart_tx_arbiter;
  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wr;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic                  fifo_full;
  logic [1:0]            grant_id;
  logic                  busy;
`ifdef UART_TX_ARB_STATS_EN
  logic [15:0]           stall_cnt;
`endif

  uart_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr      (fifo_wr),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef UART_TX_ARB_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  typedef struct packed { int id; logic [7:0] d; } exp_t;

  beat_t src_q[NREQ][$];
  exp_t  exp_q[$];
  int    wr_ids[$];
  int    wr_dat[$];
  int    wr_cyc[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_rr = NREQ - 1;
  logic [NREQ-1:0] fire = '0;
  bit full_force = 1'b0;
  bit rand_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    fire = '0;
  endtask

  task automatic clear_logs();
    wr_ids.delete();
    wr_dat.delete();
    wr_cyc.delete();
  endtask

  task automatic load_msg(input int id, input int n, input logic [7:0] base, input bit last_end);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = base + 8'(k);
      b.l = last_end && (k == n - 1);
      src_q[id].push_back(b);
    end
  endtask

  // Transaction-level model: rotate over non-empty requesters after the last
  // winner; each grant drains bytes until a last flag, MAX_BURST bytes, or the
  // requester runs out of data.
  task automatic build_expected();
    beat_t m_q[NREQ][$];
    beat_t b;
    exp_t  e;
    int    total;
    int    id;
    int    n;
    bit    stop;
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      m_q[i] = src_q[i];
      total += m_q[i].size();
    end
    while (total > 0) begin
      id = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (id < 0 && m_q[(model_rr + k) % NREQ].size() > 0) id = (model_rr + k) % NREQ;
      end
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        b = m_q[id].pop_front();
        total--;
        n++;
        e.id = id;
        e.d  = b.d;
        exp_q.push_back(e);
        stop = b.l || (n == MAX_BURST) || (m_q[id].size() == 0);
      end
      model_rr = id;
    end
  endtask

  function automatic bit src_pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_pending()) && n < 3000) begin
      @(negedge clk);
      #4;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: timeout with %0d bytes outstanding, required 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
    #4;
  endtask

  task automatic wait_first_wr(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!fifo_wr && n < 50);
    chk({name, "_first_wr"}, fifo_wr, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    model_rr = NREQ - 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle counter for write timing.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester driver: present queue heads, record handshakes, pop after the edge.
  initial begin
    beat_t tmp;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (fire[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
      end
      fifo_full = full_force || (rand_full && ($urandom_range(0, 3) == 0));
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[i*WIDTH +: WIDTH] = src_q[i][0].d;
          req_last[i] = src_q[i][0].l;
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*WIDTH +: WIDTH] = 8'($urandom);
          req_last[i] = 1'($urandom);
        end
      end
      #1;
      fire = req_valid & req_ready;
    end
  end

  // Monitor: every FIFO write is checked against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && fifo_wr) begin
        wr_ids.push_back(int'(grant_id));
        wr_dat.push_back(int'(fifo_wr_data));
        wr_cyc.push_back(cyc);
        chk("wr_while_full", fifo_full, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: got id %0d data %0h, required no write", grant_id, fifo_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_id", grant_id, e.id);
          chk("wr_data", fifo_wr_data, e.d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ids3[8];
    int exp_dat3[8];
    exp_ids3 = '{1, 1, 1, 1, 2, 2, 1, 1};
    exp_dat3 = '{'h10, 'h11, 'h12, 'h13, 'h20, 'h21, 'h14, 'h15};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
`ifdef UART_TX_ARB_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // T1: single requester, three bytes, one-cycle arbitration latency
    @(posedge clk);
    #3;
    clear_logs();
    load_msg(0, 3, 8'hA1, 1'b1);
    build_expected();
    @(negedge clk);
    #3;
    chk("t1_arb_cycle_wr", fifo_wr, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #3;
      chk("t1_wr", fifo_wr, 1);
      chk("t1_data", fifo_wr_data, 8'hA1 + k);
    end
    @(negedge clk);
    #3;
    chk("t1_busy_after", busy, 0);
    chk("t1_grant_after", grant_id, 0);
    wait_drain("t1");

    // T2: all requesters, one-byte messages -> 0,1,2,3,0 at 2 cycles per byte
    do_reset();
    @(posedge clk);
    #3;
    clear_logs();
    for (int i = 0; i < NREQ; i++) load_msg(i, 1, 8'h30 + 8'(i), 1'b1);
    load_msg(0, 1, 8'h34, 1'b1);
    build_expected();
    wait_drain("t2");
    chk("t2_count", wr_ids.size(), 5);
    for (int k = 0; k < 5 && k < wr_ids.size(); k++) begin
      chk("t2_order", wr_ids[k], k % NREQ);
      if (k > 0) chk("t2_spacing", wr_cyc[k] - wr_cyc[k-1], 2);
    end

    // T3: burst cap forces rotation mid-message
    clear_logs();
    load_msg(1, 6, 8'h10, 1'b1);
    load_msg(2, 2, 8'h20, 1'b1);
    build_expected();
    wait_drain("t3");
    chk("t3_count", wr_ids.size(), 8);
    for (int k = 0; k < 8 && k < wr_ids.size(); k++) begin
      chk("t3_id", wr_ids[k], exp_ids3[k]);
      chk("t3_data", wr_dat[k], exp_dat3[k]);
    end

    // T4: FIFO full for 5 cycles mid-burst of requester 3
    clear_logs();
    load_msg(3, 4, 8'h40, 1'b1);
    build_expected();
    wait_first_wr("t4");
    full_force = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #3;
      chk("t4_ready", req_ready, 0);
      chk("t4_wr", fifo_wr, 0);
      chk("t4_grant", grant_id, 3);
      chk("t4_busy", busy, 1);
    end
    full_force = 1'b0;
    wait_drain("t4");
    chk("t4_count", wr_ids.size(), 4);

    // T5: asynchronous reset mid-burst, then priority restarts at requester 0
    load_msg(1, 6, 8'h50, 1'b1);
    build_expected();
    wait_first_wr("t5");
    rst = 1'b1;
    #1;
    chk("t5_rst_wr", fifo_wr, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_grant", grant_id, 0);
    flush();
    model_rr = NREQ - 1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #3;
    clear_logs();
    load_msg(2, 2, 8'h62, 1'b1);
    load_msg(0, 2, 8'h60, 1'b1);
    build_expected();
    wait_drain("t5");
    chk("t5_count", wr_ids.size(), 4);
    if (wr_ids.size() > 0) chk("t5_first_grant", wr_ids[0], 0);

    // Randomized messages with random FIFO back-pressure
    rand_full = 1'b1;
    for (int r = 0; r < 10; r++) begin
      @(posedge clk);
      #3;
      for (int i = 0; i < NREQ; i++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          load_msg(i, $urandom_range(1, 6), 8'($urandom), $urandom_range(0, 3) != 0);
        end
      end
      build_expected();
      wait_drain("rand");
    end
    rand_full = 1'b0;

`ifdef UART_TX_ARB_STATS_EN
    // T6: stall counter over 10 granted-valid full cycles
    do_reset();
    full_force = 1'b1;
    @(posedge clk);
    #3;
    load_msg(0, 1, 8'h77, 1'b1);
    build_expected();
    @(negedge clk);
    repeat (11) @(negedge clk);
    #3;
    chk("t6_stall_cnt", stall_cnt, 10);
    full_force = 1'b0;
    wait_drain("t6");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
